// File: rtl/stage5_output_buffer.sv
// stage5_output_buffer: select/sign/round/saturate accepted GRNG samples into a valid/ready FIFO with stats and upstream stall
module stage5_output_buffer #(
  parameter int DEPTH    = 8,
  parameter int LOG2D    = 3,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             tail_case,
  input  logic             reject,
  input  logic [35:0]      normal_value,
  input  logic [35:0]      tail_value,
  input  logic             sign_bit,
  output logic             in_stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             clr_stats,
  output logic [31:0]      accept_cnt,
  output logic [31:0]      reject_cnt,
  output logic [31:0]      tail_cnt,
  output logic             overflow
);
  localparam int SH = 28 - OUT_FRAC;
  localparam logic signed [37:0] MAXV = (38'sd1 <<< (OUT_W - 1)) - 38'sd1;
  localparam logic signed [37:0] MINV = -(38'sd1 <<< (OUT_W - 1));
  logic [35:0]        v;
  logic signed [36:0] s;
  logic signed [37:0] rnd, r;
  logic [OUT_W-1:0]   sat, s1_data;
  logic               s1_valid, acc, rej, pop, full, wr, drop;
  logic [LOG2D-1:0]   wr_ptr, rd_ptr;
  logic [LOG2D:0]     count;
  logic [OUT_W-1:0]   mem [DEPTH];
  // 37-bit sign extension keeps -(-2^35) representable; one more bit absorbs the rounding add
  always_comb begin
    v   = tail_case ? tail_value : normal_value;
    s   = sign_bit ? -{v[35], v} : {v[35], v};
    rnd = {s[36], s} + (38'sd1 <<< (SH - 1));
    r   = rnd >>> SH;
    sat = r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
  end
  assign acc       = valid_in & ~reject;
  assign rej       = valid_in & reject;
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign full      = count == (LOG2D + 1)'(DEPTH);
  assign wr        = s1_valid & (~full | pop);
  assign drop      = s1_valid & full & ~pop;
  assign in_stall  = count >= (LOG2D + 1)'(DEPTH - 2);
  assign out_data  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    s1_data <= sat;
    if (wr) mem[wr_ptr] <= s1_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      accept_cnt <= '0;
      reject_cnt <= '0;
      tail_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      s1_valid   <= acc;
      wr_ptr     <= wr_ptr + {{(LOG2D-1){1'b0}}, wr};
      rd_ptr     <= rd_ptr + {{(LOG2D-1){1'b0}}, pop};
      count      <= count + {{LOG2D{1'b0}}, wr} - {{LOG2D{1'b0}}, pop};
      accept_cnt <= clr_stats ? '0 : accept_cnt + {31'b0, acc & ~&accept_cnt};
      reject_cnt <= clr_stats ? '0 : reject_cnt + {31'b0, rej & ~&reject_cnt};
      tail_cnt   <= clr_stats ? '0 : tail_cnt + {31'b0, acc & tail_case & ~&tail_cnt};
      overflow   <= clr_stats ? 1'b0 : overflow | drop;
    end
  end
endmodule

// File: tb/tb_stage5_output_buffer.sv
// tb_stage5_output_buffer: directed self-checking bench for stage5_output_buffer
module tb_stage5_output_buffer;
  logic        clk = 0, rst = 1;
  logic        valid_in = 0, tail_case = 0, reject = 0, sign_bit = 0;
  logic [35:0] normal_value = '0, tail_value = '0;
  logic        in_stall, out_valid, out_ready = 1, clr_stats = 0, overflow;
  logic [15:0] out_data;
  logic [31:0] accept_cnt, reject_cnt, tail_cnt;
  int errs = 0, checks = 0;
  stage5_output_buffer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .tail_case(tail_case), .reject(reject),
    .normal_value(normal_value), .tail_value(tail_value), .sign_bit(sign_bit),
    .in_stall(in_stall), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_stats(clr_stats), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt),
    .tail_cnt(tail_cnt), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic t, input logic r, input logic [35:0] nv, input logic [35:0] tv, input logic sg);
    valid_in = 1; tail_case = t; reject = r; normal_value = nv; tail_value = tv; sign_bit = sg;
  endtask
  task automatic one(input string tag, input logic t, input logic [35:0] nv, input logic [35:0] tv, input logic sg, input logic [15:0] exp);
    @(negedge clk); put(t, 0, nv, tv, sg);
    @(negedge clk); valid_in = 0; chk({tag, "_lat"}, 32'(out_valid), 0);
    @(negedge clk); chk({tag, "_vld"}, 32'(out_valid), 1); chk(tag, 32'(out_data), 32'(exp));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0); chk("rst_stall", 32'(in_stall), 0);
    chk("rst_ovf", 32'(overflow), 0); chk("rst_acc", accept_cnt, 0);
    chk("rst_rej", reject_cnt, 0); chk("rst_tail", tail_cnt, 0);
    rst = 0;
    one("pos1", 0, 36'h010000000, '0, 0, 16'h0800);
    one("neg1", 0, 36'h010000000, '0, 1, 16'hF800);
    chk("acc2", accept_cnt, 2); chk("tail0", tail_cnt, 0);
    one("half", 0, 36'h000010000, '0, 0, 16'h0001);
    one("below", 0, 36'h00000FFFF, '0, 0, 16'h0000);
    one("neghalf", 0, 36'h000010000, '0, 1, 16'h0000);
    one("satp", 1, '0, 36'h140000000, 0, 16'h7FFF);
    one("satn", 1, '0, 36'h140000000, 1, 16'h8000);
    chk("tail2", tail_cnt, 2); chk("acc7", accept_cnt, 7);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); chk("rej_vld", 32'(out_valid), 0); put(0, 1, 36'h010000000, '0, 0);
    end
    @(negedge clk); valid_in = 0; reject = 0;
    repeat (2) @(negedge clk);
    chk("rej_vld_end", 32'(out_valid), 0); chk("rej5", reject_cnt, 5); chk("rej_acc", accept_cnt, 7);
    out_ready = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk); chk("bp_stall", 32'(in_stall), 32'(j >= 7)); put(0, 0, 36'(j + 1) << 17, '0, 0);
    end
    @(negedge clk); valid_in = 0;
    repeat (2) @(negedge clk);
    chk("bp_ovf", 32'(overflow), 1); chk("bp_stall_full", 32'(in_stall), 1);
    chk("bp_acc", accept_cnt, 17);
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_vld", 32'(out_valid), 1); chk("drain", 32'(out_data), k); @(negedge clk);
    end
    chk("drain_empty", 32'(out_valid), 0);
    clr_stats = 1; put(1, 0, '0, 36'h140000000, 0);
    @(negedge clk); clr_stats = 0; valid_in = 0;
    chk("clr_acc", accept_cnt, 0); chk("clr_tail", tail_cnt, 0);
    chk("clr_rej", reject_cnt, 0); chk("clr_ovf", 32'(overflow), 0);
    repeat (3) @(negedge clk);
    out_ready = 0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk); put(0, 0, 36'(j + 1) << 17, '0, 0);
    end
    @(negedge clk); valid_in = 0; out_ready = 1; chk("fp_head", 32'(out_data), 1);
    @(negedge clk); out_ready = 0;
    chk("fp_ovf", 32'(overflow), 0); chk("fp_stall", 32'(in_stall), 1); chk("fp_head2", 32'(out_data), 2);
    out_ready = 1;
    for (int k = 2; k <= 9; k++) begin
      chk("fp_vld", 32'(out_valid), 1); chk("fp_drain", 32'(out_data), k); @(negedge clk);
    end
    chk("fp_empty", 32'(out_valid), 0); chk("fp_acc", accept_cnt, 9);
    out_ready = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk); put(0, 0, 36'(j + 1) << 17, '0, 0);
    end
    @(negedge clk); valid_in = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_vld", 32'(out_valid), 1); chk("pre_rst_stall", 32'(in_stall), 1); chk("pre_rst_acc", accept_cnt, 16);
    #2 rst = 1;
    #1 chk("arst_vld", 32'(out_valid), 0); chk("arst_stall", 32'(in_stall), 0);
    chk("arst_acc", accept_cnt, 0); chk("arst_tail", tail_cnt, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_vld", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/stage5_output_buffer.md
# stage5_output_buffer

Final stage of the GRNG core pipeline; sits directly after the Stage4 accept/reject stage. Each cycle it takes one Stage4 result and drops it if it was rejected. Accepted samples are handled as follows:
- select the normal or tail value;
- apply a random sign;
- round and saturate the Q7.28 value to a narrow output format;
- buffer the result in a small FIFO with a valid/ready interface toward the consumer.

The block also maintains acceptance statistics and raises a stall to upstream before the FIFO can overflow.

## Interface
- DEPTH, 8: FIFO entries. Power of two, ≥ 4.
- LOG2D, 3: log2(DEPTH).
- OUT_W, 16: output sample width, signed two's complement.
- OUT_FRAC, 11: fractional bits of the output (default format Q5.11). Constraint: OUT_FRAC ≤ 27.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  Stage4 result present this cycle.
- tail_case  in  1  1 selects tail_value, 0 selects normal_value.
- reject  in  1  1 means the sample is discarded.
- normal_value  in  36  signed Q7.28.
- tail_value  in  36  signed Q7.28.
- sign_bit  in  1  random sign; 1 negates the sample.
- in_stall  out  1  upstream must hold off new samples.
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  consumer accepts the sample this cycle.
- out_data  out  OUT_W  signed output sample.
- clr_stats  in  1  synchronous clear of all counters and overflow.
- accept_cnt  out  32  number of accepted samples.
- reject_cnt  out  32  number of rejected samples.
- tail_cnt  out  32  number of accepted samples that were tail cases.
- overflow  out  1  sticky; a sample was dropped.

## Operation
- Accept condition: valid_in & ~reject. A rejected input (valid_in & reject) increments reject_cnt only.
- Selection: v = tail_case ? tail_value : normal_value.
- Sign: s = sign_bit ? −v : v, computed sign-extended to 37 bits so that −(−2^35) does not overflow.
- Rounding is round-half-up:
  - SH = 28 − OUT_FRAC;
  - r = (s + 2^(SH−1)) >>> SH, an arithmetic shift at full width.
- Saturation: clamp r to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Stage S1 register holds the rounded value plus s1_valid (= accept condition). S1 updates every cycle.
- FIFO push occurs when s1_valid is 1. Pop occurs on out_valid & out_ready.
- FIFO bookkeeping:
  - count has LOG2D+1 bits;
  - read and write pointers have LOG2D bits and wrap modulo DEPTH.
- Push while full:
  - with a simultaneous pop, both operations proceed and count is unchanged;
  - with no pop, the sample is dropped, overflow is set (sticky), and accept_cnt still increments.
- Pop while empty is impossible, since out_valid = (count ≠ 0).
- Push and pop while empty: no bypass. The sample is written and count becomes 1.
- out_data is the FIFO head entry. Its value is don't-care when out_valid is 0.
- in_stall = (count ≥ DEPTH − 2). This covers the S1 register plus one upstream sample in flight.
- Counters:
  - accept_cnt increments on the accept condition (input side, not S1);
  - tail_cnt increments on the accept condition & tail_case;
  - all counters saturate at 2^32−1.
- clr_stats zeroes accept_cnt, reject_cnt, tail_cnt and overflow. An increment in the same cycle is lost, because clear wins.
- Reset clears s1_valid, count, both pointers, all counters and overflow. FIFO RAM contents are not reset. A reset mid-stream discards all buffered samples.
- Reset values: out_valid 0, in_stall 0, overflow 0, all counters 0. out_data is undefined.

## Timing
- Latency: a sample accepted in cycle N is written to the FIFO at the end of cycle N+1. If the FIFO was empty, out_valid = 1 in cycle N+2.
- Throughput: one sample per cycle in and out. A full FIFO sustains full rate when out_ready is held at 1.
- in_stall is combinational from count (a registered quantity). It asserts in the cycle after count reaches DEPTH−2.
- Counters update on the edge ending the cycle in which the event occurred.

## Test plan
- Normal value 0x010000000 (1.0), sign 0 → out_data 0x0800 at cycle N+2. The same value with sign 1 → 0xF800. accept_cnt = 2, tail_cnt = 0.
- Rounding:
  - 0x000010000 (half LSB) → 0x0001;
  - 0x00000FFFF → 0x0000;
  - −0x000010000 → 0x0000.
- Saturation: tail value 20.0 (0x140000000) with tail_case = 1 → 0x7FFF; with sign 1 → 0x8000. tail_cnt = 2.
- reject = 1 on 5 valid inputs → no out_valid, reject_cnt = 5, accept_cnt unchanged.
- Backpressure, with out_ready = 0 and 10 consecutive accepts:
  - in_stall asserts once count reaches 6;
  - count stops at 8 and overflow = 1;
  - after releasing out_ready, the first 8 samples drain in order.
- Full FIFO with simultaneous push and pop → count stays 8 and overflow stays 0. Assert rst mid-stream → out_valid = 0 immediately (asynchronous), counters read 0.
